// File: rtl/uart_rx.sv
// 8N1 serial receiver with a small first-word-fall-through receive FIFO.
// Each bit is sampled near its centre; completed bytes are pushed one clock after the stop-bit sample.
module uart_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  input  logic       uart_clr_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_ferr_o,
  output logic       uart_ovf_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int NW           = AW + 1;

  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FIFO_FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // Both flops reset high so a reset release never looks like a start bit.
  logic rx_meta_reg;
  logic rx_s_reg;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic          push_reg;
  logic          ferr_reg;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      push_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      // A framing error later in this block overrides the clear.
      if (uart_clr_i) begin
        ferr_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s_reg) begin
            state_reg <= START;
          end
        end
        START: begin
          if (cnt_reg == CNT_HALF_LAST) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            if (rx_s_reg) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rx_s_reg;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s_reg) begin
              push_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        WAIT_HIGH: begin
          // Holding here keeps a break condition from decoding as endless 0x00 frames.
          cnt_reg <= '0;
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [NW-1:0] count_reg;
  logic          ovf_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic [7:0]    entry_data [FIFO_DEPTH];

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign do_pop     = uart_rd_i && !fifo_empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_reg && (!fifo_full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [7:0] data_reg;
      logic       wr_sel;

      assign wr_sel = do_push && (wr_ptr_reg == AW'(gi));

      always_ff @(posedge sys_clk_i) begin
        if (wr_sel) begin
          data_reg <= shift_reg;
        end
      end

      assign entry_data[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + NW'(1);
        2'b01:   count_reg <= count_reg - NW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_reg && !do_push) begin
        ovf_reg <= 1'b1;
      end else if (uart_clr_i) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign uart_dat_o   = fifo_empty ? 8'h00 : entry_data[rd_ptr_reg];
  assign uart_valid_o = !fifo_empty;
  assign uart_ferr_o  = ferr_reg;
  assign uart_ovf_o   = ovf_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit rate (32 clocks per bit).
// Expected bytes, flags and the push latency are worked out by hand from the frame timing.
module tb_uart_rx;

  localparam int CLK_HZ = 3200000;
  localparam int BAUD   = 100000;
  localparam int CPB    = 32;
  localparam int HB     = 16;
  // 2 synchronizer clocks + IDLE detect + HALF_BIT + 9 bits + 1 FIFO write.
  localparam int LAT    = 4 + HB + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rd;
  logic       clr;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovf;

  int checks;
  int errors;

  uart_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rstn_i  (rst_n),
    .uart_rx_i   (rx),
    .uart_rd_i   (rd),
    .uart_clr_i  (clr),
    .uart_dat_o  (dat),
    .uart_valid_o(valid),
    .uart_ferr_o (ferr),
    .uart_ovf_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB * stop_len);
    rx = 1'b1;
  endtask

  task automatic pop;
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] byte_a;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rx     = 1'b1;
    rd     = 1'b0;
    clr    = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_dat", {24'd0, dat}, 32'h00);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single frame with exact push latency.
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        tick(LAT - 1);
        chk("lat_before", {31'd0, valid}, 32'd0);
        tick(1);
        chk("lat_valid", {31'd0, valid}, 32'd1);
        chk("a5_dat", {24'd0, dat}, 32'hA5);
      end
    join
    tick(CPB);
    chk("a5_ferr", {31'd0, ferr}, 32'd0);
    chk("a5_ovf", {31'd0, ovf}, 32'd0);
    pop();
    chk("a5_pop_valid", {31'd0, valid}, 32'd0);
    chk("a5_pop_dat", {24'd0, dat}, 32'h00);
    pop();
    chk("empty_pop_valid", {31'd0, valid}, 32'd0);

    // Short low glitch rejected at the half-bit check.
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(2 * CPB);
    chk("glitch_valid", {31'd0, valid}, 32'd0);
    chk("glitch_ferr", {31'd0, ferr}, 32'd0);

    // Framing error followed by a good frame.
    send_frame(8'h3C, 1'b0, 3);
    tick(CPB);
    chk("ferr_set", {31'd0, ferr}, 32'd1);
    chk("ferr_no_push", {31'd0, valid}, 32'd0);
    send_frame(8'h55, 1'b1, 1);
    tick(CPB);
    chk("55_valid", {31'd0, valid}, 32'd1);
    chk("55_dat", {24'd0, dat}, 32'h55);
    chk("ferr_sticky", {31'd0, ferr}, 32'd1);
    pulse_clr();
    chk("ferr_clr", {31'd0, ferr}, 32'd0);
    pop();
    chk("55_pop_valid", {31'd0, valid}, 32'd0);

    // Overrun: five back-to-back frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      byte_a = 8'(i);
      send_frame(byte_a, 1'b1, 1);
    end
    tick(CPB);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), {24'd0, dat}, 32'(i));
      pop();
    end
    chk("ovf_drained", {31'd0, valid}, 32'd0);
    pulse_clr();
    chk("ovf_clr", {31'd0, ovf}, 32'd0);

    // Push and pop in the same cycle while full.
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    send_frame(8'h33, 1'b1, 1);
    send_frame(8'h44, 1'b1, 1);
    fork
      send_frame(8'h99, 1'b1, 1);
      begin
        tick(LAT - 1);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
      end
    join
    tick(CPB);
    chk("full_rw_ovf", {31'd0, ovf}, 32'd0);
    chk("full_rw_head", {24'd0, dat}, 32'h22);
    chk("full_rw_pop1", {24'd0, dat}, 32'h22);
    pop();
    chk("full_rw_pop2", {24'd0, dat}, 32'h33);
    pop();
    chk("full_rw_pop3", {24'd0, dat}, 32'h44);
    pop();
    chk("full_rw_pop4", {24'd0, dat}, 32'h99);
    pop();
    chk("full_rw_empty", {31'd0, valid}, 32'd0);

    // Asynchronous reset in the middle of a frame.
    send_frame(8'h66, 1'b1, 1);
    tick(CPB);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    byte_a = 8'h7E;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = byte_a[i];
      tick(CPB);
    end
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_dat", {24'd0, dat}, 32'h00);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(12 * CPB);
    chk("rst_no_push", {31'd0, valid}, 32'd0);
    send_frame(8'h42, 1'b1, 1);
    tick(CPB);
    chk("42_valid", {31'd0, valid}, 32'd1);
    chk("42_dat", {24'd0, dat}, 32'h42);
    pop();
    chk("42_only", {31'd0, valid}, 32'd0);
    chk("end_ferr", {31'd0, ferr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver counterpart to the existing `uart` transmitter.
- Receives 8N1 frames on the external RX pin and buffers completed bytes in a small FIFO.
- Exposes head byte, status flags and a pop strobe so the Memory Access stage can service a load from the UART receive address.
- Sits next to `uart` at the cpu top level and shares sysclk and cpu_resetn.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, number of receive buffer entries; must be a power of two and at least 2.
- Derived: CLKS_PER_BIT = CLK_HZ/BAUD, integer floor (868 at defaults). HALF_BIT = CLKS_PER_BIT/2 (434).

Ports:
- sys_clk_i  input  1  system clock, rising edge.
- sys_rstn_i  input  1  reset, asynchronous, active-low.
- uart_rx_i  input  1  serial line, idle high, asynchronous to sys_clk_i.
- uart_rd_i  input  1  pop strobe, one cycle; removes the head entry.
- uart_clr_i  input  1  clears the sticky error flags.
- uart_dat_o  output  8  FIFO head byte; 8'h00 when empty.
- uart_valid_o  output  1  FIFO not empty.
- uart_ferr_o  output  1  sticky framing error.
- uart_ovf_o  output  1  sticky overrun.

Behaviour:
- Reset, asynchronous while sys_rstn_i=0:
  - FSM goes to IDLE; bit counter and bit index go to 0.
  - Both synchronizer flops are set to 1.
  - FIFO pointers and count go to 0, so uart_valid_o=0 and uart_dat_o=8'h00.
  - uart_ferr_o=0, uart_ovf_o=0.
  - Reset mid-frame discards the partial byte; no push occurs.
- Input sync: two-flop synchronizer on uart_rx_i. All FSM decisions use the second flop (rx_s).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START:
    - Count while cnt<HALF_BIT-1.
    - At cnt=HALF_BIT-1, sample rx_s. If 1, treat it as a glitch and return to IDLE with no flags set. If 0, go to DATA with cnt=0 and idx=0.
  - DATA:
    - At cnt=CLKS_PER_BIT-1, sample rx_s into shift[idx], LSB first, and set cnt=0.
    - After idx=7 is sampled, go to STOP. Otherwise increment idx.
  - STOP:
    - At cnt=CLKS_PER_BIT-1, sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: set ferr, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Sampling point: every bit is sampled at its centre, ±1 clock.
- Latency: the push occurs HALF_BIT+9*CLKS_PER_BIT clocks after IDLE detects rx_s=0. uart_valid_o rises on the following clock edge.
- Back-to-back frames: IDLE accepts a new start bit on the cycle after STOP exits. No idle gap is required beyond the stop bit.
- FIFO behaviour:
  - First-word-fall-through: uart_dat_o shows the head combinationally from the registered storage.
  - Pop when empty is ignored.
  - Push when full with no pop in the same cycle: byte dropped, ovf set, contents unchanged.
  - Push and pop in the same cycle, FIFO non-empty: both take effect, count unchanged, no overrun even when full.
  - Push and pop in the same cycle, FIFO empty: the pop is ignored and the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH. Count has log2(FIFO_DEPTH)+1 bits.
- Sticky flags:
  - ferr and ovf hold until uart_clr_i=1.
  - If a set event and uart_clr_i fall in the same cycle, set wins.
  - Flags do not block reception.

Test Plan:
- Defaults, drive 8N1 byte 0xA5 at 868 clk/bit -> exactly one push. uart_valid_o=1 and uart_dat_o=0xA5 at the specified latency+1. Flags stay 0. Pulse uart_rd_i -> uart_valid_o=0 and uart_dat_o=0x00.
- Low glitch of 200 clocks on the idle line -> FSM returns to IDLE at the HALF_BIT check. No push and no flags.
- Frame 0x3C with stop bit 0, line held low 3 bit-times, then high -> uart_ferr_o=1, no push. The next valid frame 0x55 is received correctly. uart_clr_i pulse -> ferr=0.
- Send 0x01..0x05 with no pops -> first 4 stored, uart_ovf_o=1. Pops return 0x01, 0x02, 0x03, 0x04 in order, then uart_valid_o=0.
- FIFO full; assert uart_rd_i in the exact cycle a new byte 0x99 is pushed -> no overrun, count stays 4. The head advances, and 0x99 is the last entry popped.
- Assert sys_rstn_i=0 for 3 clocks during DATA of byte 0x7E (asynchronous to the clock edge) -> outputs go to reset values immediately. Release with the line idle high, then send 0x42 -> only 0x42 is received.
